gcd_controller: RTL and testbench
=================================

Name: gcd_controller

Overview:
- Control FSM that sequences the 16-bit subtract-and-compare GCD datapath: operand register loads A/B, operand mux selects, load-bus mux select.
- Accepts two operands over a valid/ready handshake on the shared data_in bus.
- Iterates subtract-and-compare until the comparator reports equality, then signals done; GCD result is read from register A.
- Bounded iteration counter aborts runaway cases (zero operand) with an error flag.

Parameters:
- CNT_W, 16, width of the iteration counter.
- MAX_ITER, 65535, subtraction budget before abort; must be < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  begin a computation; sampled only in IDLE
- in_valid  input  1  operand present on datapath data_in
- in_ready  output  1  controller will load data_in on this edge if in_valid
- gt  input  1  comparator: A > B
- lt  input  1  comparator: A < B
- eq  input  1  comparator: A == B
- ldA  output  1  load register A from bus
- ldB  output  1  load register B from bus
- sel1  output  1  minuend mux: 0 = A, 1 = B
- sel2  output  1  subtrahend mux: 0 = A, 1 = B
- sel_in  output  1  bus mux: 1 = data_in, 0 = subtractor output
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of computation (success or abort)
- err  output  1  one-cycle pulse with done when aborted
- iter_cnt  output  CNT_W  subtractions performed in current/last run

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, RUN, DONE, ERR. State and iter_cnt registered; control outputs decoded combinationally from state, flags and in_valid.
- Reset (asynchronous, any state, mid-run included): state = IDLE, iter_cnt = 0; all outputs 0 while rst high and in IDLE.
- IDLE: all outputs 0. start=1 -> LOAD_A, iter_cnt cleared to 0 on the same edge.
- LOAD_A: in_ready=1, sel_in=1. ldA = in_valid. in_valid -> LOAD_B; otherwise hold indefinitely.
- LOAD_B: same as LOAD_A with ldB. in_valid -> RUN.
- RUN, per cycle, priority eq > budget > gt > lt:
  - eq -> DONE, no load.
  - iter_cnt == MAX_ITER -> ERR, no load.
  - gt: sel1=0, sel2=1, sel_in=0, ldA=1 (A <= A-B); iter_cnt += 1; stay.
  - lt: sel1=1, sel2=0, sel_in=0, ldB=1 (B <= B-A); iter_cnt += 1; stay.
  - No flag asserted (illegal) -> ERR.
- Flags are combinational from the registered A/B, so each RUN cycle sees the previous subtraction's result. One subtraction per cycle.
- DONE: done=1 for one cycle -> IDLE.
- ERR: done=1, err=1 for one cycle -> IDLE.
- start is ignored outside IDLE, including the DONE/ERR cycle.
- iter_cnt holds its final value until the next accepted start. It never wraps; MAX_ITER bounds it.
- Latency from start: 1 + operand stalls + 2 load cycles + (N subtractions + 1 compare) + 1 done cycle.
- Zero operand: A=0, B>0 loops on lt with no progress and ends in ERR after MAX_ITER subtractions. Both operands 0 gives eq and completes with GCD 0.

Decomposition:
- Shared package: state encoding constants (IDLE..ERR), mux select constants SEL_A=0, SEL_B=1, BUS_SUB=0, BUS_IN=1.
- Single module; no sub-module is warranted.
- A top-level wrapper pairing this controller with the datapath is a separate block.

Test Plan:
- A=48, B=18 (in_valid high throughout) -> 4 subtractions, done pulse, err=0, A register = 6, iter_cnt=4, busy high from cycle after start to the done cycle inclusive.
- A=7, B=7 -> eq on first RUN cycle, iter_cnt=0, no ldA/ldB in RUN, result 7.
- A=13, B=1 -> 12 subtractions on the gt path, result 1; in_valid held low for 3 cycles in LOAD_A -> in_ready stays high, no ldA until in_valid, total latency +3.
- MAX_ITER=10, A=0, B=5 -> 10 lt subtractions then ERR: done=1, err=1 same cycle, iter_cnt=10, back to IDLE.
- rst asserted during RUN of A=48, B=18 -> immediately IDLE, iter_cnt=0, outputs 0. Fresh start A=21, B=14 then gives result 7, iter_cnt=2.
- start pulsed during RUN and during the DONE cycle -> ignored: no restart, iter_cnt unchanged.

Source files
------------

// File: rtl/gcd_controller_pkg.sv
// Shared encodings for the GCD controller: FSM states and datapath mux selects.
package gcd_controller_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      RUN    = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } state_e;

   localparam logic SEL_A   = 1'b0;
   localparam logic SEL_B   = 1'b1;
   localparam logic BUS_SUB = 1'b0;
   localparam logic BUS_IN  = 1'b1;

endpackage

// File: rtl/gcd_controller.sv
// Control FSM for the subtract-and-compare GCD datapath, with a bounded
// iteration budget that aborts non-converging (zero operand) runs.
module gcd_controller
   import gcd_controller_pkg::*;
#(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_ITER = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             gt,
   input  logic             lt,
   input  logic             eq,
   output logic             ldA,
   output logic             ldB,
   output logic             sel1,
   output logic             sel2,
   output logic             sel_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] iter_cnt
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] iter_q, iter_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   // Next state, counter update and control decode; outputs follow state/flags directly.
   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      in_ready = 1'b0;
      ldA      = 1'b0;
      ldB      = 1'b0;
      sel1     = SEL_A;
      sel2     = SEL_A;
      sel_in   = BUS_SUB;
      busy     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_A;
               iter_d  = '0;
            end
         end
         LOAD_A: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = BUS_IN;
            ldA      = in_valid;
            if (in_valid) state_d = LOAD_B;
         end
         LOAD_B: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            sel_in   = BUS_IN;
            ldB      = in_valid;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            // Equality wins over the budget so a run finishing on the last allowed step succeeds.
            if (eq) begin
               state_d = DONE;
            end else if (iter_q == CNT_W'(MAX_ITER)) begin
               state_d = ERR;
            end else if (gt) begin
               sel1   = SEL_A;
               sel2   = SEL_B;
               sel_in = BUS_SUB;
               ldA    = 1'b1;
               iter_d = iter_q + CNT_W'(1);
            end else if (lt) begin
               sel1   = SEL_B;
               sel2   = SEL_A;
               sel_in = BUS_SUB;
               ldB    = 1'b1;
               iter_d = iter_q + CNT_W'(1);
            end else begin
               state_d = ERR;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            busy    = 1'b1;
            done    = 1'b1;
            err     = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign iter_cnt = iter_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller: two instances (default budget and a
// budget of 10), each paired with a behavioural subtract-and-compare datapath.
module tb_gcd_controller;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned MAX0  = 65535;
   localparam int unsigned MAX1  = 10;

   typedef struct {
      logic [15:0] gcd;
      int          iters;
      bit          err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, in_valid;
   logic [15:0] data_in;
   bit          sel;

   logic gt_0, lt_0, eq_0, in_ready_0, ldA_0, ldB_0, sel1_0, sel2_0, sel_in_0, busy_0, done_0, err_0;
   logic gt_1, lt_1, eq_1, in_ready_1, ldA_1, ldB_1, sel1_1, sel2_1, sel_in_1, busy_1, done_1, err_1;
   logic [CNT_W-1:0] iter_0, iter_1;
   logic [15:0] a0_q, b0_q, bus0, a1_q, b1_q, bus1;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_0),
      .gt(gt_0), .lt(lt_0), .eq(eq_0), .ldA(ldA_0), .ldB(ldB_0), .sel1(sel1_0), .sel2(sel2_0),
      .sel_in(sel_in_0), .busy(busy_0), .done(done_0), .err(err_0), .iter_cnt(iter_0));

   gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(MAX1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_1),
      .gt(gt_1), .lt(lt_1), .eq(eq_1), .ldA(ldA_1), .ldB(ldB_1), .sel1(sel1_1), .sel2(sel2_1),
      .sel_in(sel_in_1), .busy(busy_1), .done(done_1), .err(err_1), .iter_cnt(iter_1));

   // Behavioural datapaths: operand registers, subtractor, bus mux, comparator.
   always_comb bus0 = sel_in_0 ? data_in : ((sel1_0 ? b0_q : a0_q) - (sel2_0 ? b0_q : a0_q));
   always_comb bus1 = sel_in_1 ? data_in : ((sel1_1 ? b1_q : a1_q) - (sel2_1 ? b1_q : a1_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a0_q <= '0; b0_q <= '0; a1_q <= '0; b1_q <= '0;
      end else begin
         if (ldA_0) a0_q <= bus0;
         if (ldB_0) b0_q <= bus0;
         if (ldA_1) a1_q <= bus1;
         if (ldB_1) b1_q <= bus1;
      end
   end

   assign gt_0 = a0_q > b0_q;  assign lt_0 = a0_q < b0_q;  assign eq_0 = a0_q == b0_q;
   assign gt_1 = a1_q > b1_q;  assign lt_1 = a1_q < b1_q;  assign eq_1 = a1_q == b1_q;

   wire in_ready_s = sel ? in_ready_1 : in_ready_0;
   wire ldA_s      = sel ? ldA_1 : ldA_0;
   wire ldB_s      = sel ? ldB_1 : ldB_0;
   wire busy_s     = sel ? busy_1 : busy_0;
   wire done_s     = sel ? done_1 : done_0;
   wire err_s      = sel ? err_1 : err_0;
   wire eq_s       = sel ? eq_1 : eq_0;
   wire [CNT_W-1:0] iter_s = sel ? iter_1 : iter_0;
   wire [15:0]      a_s    = sel ? a1_q : a0_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference Euclid by subtraction with the same abort budget.
   function automatic exp_t gcd_model(input logic [15:0] a, input logic [15:0] b, input int max_it);
      exp_t e;
      e.iters = 0;
      e.err   = 1'b0;
      e.gcd   = '0;
      forever begin
         if (a == b) begin
            e.gcd = a;
            return e;
         end
         if (e.iters == max_it) begin
            e.err = 1'b1;
            return e;
         end
         if (a > b) a = a - b;
         else       b = b - a;
         e.iters++;
      end
   endfunction

   always @(negedge clk) begin
      if (!rst && done_s) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_done", 32'(done_s), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check_eq("err_flag", 32'(err_s), 32'(mon_e.err));
            check_eq("iter_cnt_done", 32'(iter_s), 32'(mon_e.iters));
            check_eq("busy_at_done", 32'(busy_s), 32'd1);
            if (!mon_e.err) check_eq("gcd_result", 32'(a_s), 32'(mon_e.gcd));
         end
      end
   end

   // Called at posedge+1 with the selected DUT in IDLE; returns at posedge+1 back in IDLE.
   task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input int stall, input bit poke);
      exp_t e;
      int   lat;
      bit   seen;
      e = gcd_model(a, b, sel ? int'(MAX1) : int'(MAX0));
      sb_q.push_back(e);
      start = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1; start = 1'b0; lat = 1;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_eq("stall_in_ready", 32'(in_ready_s), 32'd1);
         check_eq("stall_no_ldA", 32'(ldA_s), 32'd0);
         @(posedge clk); #1; lat++;
      end
      in_valid = 1'b1; data_in = a;
      @(negedge clk); check_eq("ldA_on_valid", 32'(ldA_s), 32'd1);
      @(posedge clk); #1; lat++;
      data_in = b;
      @(negedge clk); check_eq("ldB_on_valid", 32'(ldB_s), 32'd1);
      @(posedge clk); #1; lat++;
      in_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         if (poke) start = 1'b1;
         @(negedge clk);
         if (done_s) seen = 1'b1;
         else begin
            if (eq_s) check_eq("eq_no_load", 32'({ldA_s, ldB_s}), 32'd0);
            @(posedge clk); #1; lat++;
         end
      end
      if (!seen) begin
         check_eq("done_timeout", 32'd0, 32'd1);
         void'(sb_q.pop_back());
      end else begin
         check_eq("latency", 32'(lat + 1), 32'(stall + e.iters + 5));
      end
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      check_eq("idle_busy", 32'(busy_s), 32'd0);
      check_eq("idle_in_ready", 32'(in_ready_s), 32'd0);
      check_eq("iter_hold", 32'(iter_s), 32'(e.iters));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0; sel = 1'b0;
      @(negedge clk);
      check_eq("rst_busy", 32'(busy_0), 32'd0);
      check_eq("rst_iter", 32'(iter_0), 32'd0);
      check_eq("rst_ctrl", 32'({in_ready_0, ldA_0, ldB_0, sel_in_0, done_0, err_0}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;

      run_gcd(16'd48, 16'd18, 0, 1'b0);
      run_gcd(16'd7,  16'd7,  0, 1'b0);
      run_gcd(16'd13, 16'd1,  3, 1'b0);

      // Reset in the middle of a RUN phase.
      start = 1'b1;
      @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; data_in = 16'd48;
      @(posedge clk); #1; data_in = 16'd18;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3; rst = 1'b1; #1;
      check_eq("midrun_rst_busy", 32'(busy_0), 32'd0);
      check_eq("midrun_rst_iter", 32'(iter_0), 32'd0);
      check_eq("midrun_rst_ctrl", 32'({in_ready_0, ldA_0, ldB_0, done_0, err_0}), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      @(posedge clk); #1;
      run_gcd(16'd21, 16'd14, 0, 1'b0);

      run_gcd(16'd48, 16'd18, 0, 1'b1);
      run_gcd(16'd0,  16'd0,  0, 1'b0);

      sel = 1'b1;
      run_gcd(16'd0, 16'd5, 0, 1'b0);

      check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
